// File: rtl/key_event_decoder.sv
// key_event_decoder: turns a debounced active-low key level into single-cycle
// UI events (press, release, click, double click, long press, auto-repeat)
// plus a held-level flag. All timing is counted in clock cycles.
module key_event_decoder #(
  parameter int N         = 32,
  parameter int FREQ      = 50,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int DCLICK_MS = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_press,
  output logic key_release,
  output logic key_click,
  output logic key_dclick,
  output logic key_long,
  output logic key_repeat,
  output logic key_held
);

  localparam int LONG_CYC = LONG_MS * 1000 * FREQ;
  localparam int REP_CYC  = REPEAT_MS * 1000 * FREQ;
  localparam int DCL_CYC  = DCLICK_MS * 1000 * FREQ;

  // Terminal counter values: the event fires when cnt reaches CYC-1.
  localparam logic [N-1:0] LONG_LAST = N'(LONG_CYC - 1);
  localparam logic [N-1:0] REP_LAST  = N'(REP_CYC - 1);
  localparam logic [N-1:0] DCL_LAST  = N'(DCL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } state_t;

  state_t       state_r, next_state_s;
  logic [N-1:0] cnt_r, cnt_next_s;
  logic         d0_r, d1_r, fall_r, rise_r;
  logic         cnt_clr_s, held_s;
  logic         press_s, release_s, click_s, dclick_s, long_s, repeat_s;
  logic         press_r, release_r, click_r, dclick_r, long_r, repeat_r, held_r;

  // Key level history and edge flags; the edge flags are registered so an
  // input change shows up on the event outputs two edges after it is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_r   <= 1'b1;
      d1_r   <= 1'b1;
      fall_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      d0_r   <= key_in;
      d1_r   <= d0_r;
      fall_r <= d1_r & ~d0_r;
      rise_r <= ~d1_r & d0_r;
    end
  end

  // Next-state and event decode; an edge always beats a counter terminal value.
  always_comb begin
    next_state_s = state_r;
    cnt_clr_s    = 1'b0;
    press_s      = 1'b0;
    release_s    = 1'b0;
    click_s      = 1'b0;
    dclick_s     = 1'b0;
    long_s       = 1'b0;
    repeat_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (fall_r) begin
          next_state_s = S_PRESS1;
          press_s      = 1'b1;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_PRESS1: begin
        if (rise_r) begin
          next_state_s = S_WAIT2;
          release_s    = 1'b1;
        end else if (cnt_r == LONG_LAST) begin
          next_state_s = S_LONG;
          long_s       = 1'b1;
        end else begin
          next_state_s = S_PRESS1;
        end
      end
      S_WAIT2: begin
        if (fall_r) begin
          next_state_s = S_PRESS2;
          press_s      = 1'b1;
        end else if (cnt_r == DCL_LAST) begin
          next_state_s = S_IDLE;
          click_s      = 1'b1;
        end else begin
          next_state_s = S_WAIT2;
        end
      end
      S_PRESS2: begin
        if (rise_r) begin
          next_state_s = S_IDLE;
          release_s    = 1'b1;
          dclick_s     = 1'b1;
        end else if (cnt_r == LONG_LAST) begin
          // Holding the second press turns it into a long press; the pending
          // click is dropped for good.
          next_state_s = S_LONG;
          long_s       = 1'b1;
        end else begin
          next_state_s = S_PRESS2;
        end
      end
      S_LONG: begin
        if (rise_r) begin
          next_state_s = S_IDLE;
          release_s    = 1'b1;
        end else if (cnt_r == REP_LAST) begin
          next_state_s = S_LONG;
          repeat_s     = 1'b1;
          cnt_clr_s    = 1'b1;
        end else begin
          next_state_s = S_LONG;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Counter: cleared on every transition or repeat, runs in every non-idle state.
  always_comb begin
    cnt_next_s = {N{1'b0}};
    if ((next_state_s != state_r) || cnt_clr_s) begin
      cnt_next_s = {N{1'b0}};
    end else if (state_r == S_IDLE) begin
      cnt_next_s = {N{1'b0}};
    end else begin
      cnt_next_s = cnt_r + N'(1'b1);
    end
  end

  // Held flag follows the state the FSM is about to enter.
  always_comb begin
    held_s = 1'b0;
    case (next_state_s)
      S_PRESS1, S_PRESS2, S_LONG: held_s = 1'b1;
      default:                    held_s = 1'b0;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= {N{1'b0}};
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Output registers: every pulse is exactly one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      click_r   <= 1'b0;
      dclick_r  <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      press_r   <= press_s;
      release_r <= release_s;
      click_r   <= click_s;
      dclick_r  <= dclick_s;
      long_r    <= long_s;
      repeat_r  <= repeat_s;
      held_r    <= held_s;
    end
  end

  assign key_press   = press_r;
  assign key_release = release_r;
  assign key_click   = click_r;
  assign key_dclick  = dclick_r;
  assign key_long    = long_r;
  assign key_repeat  = repeat_r;
  assign key_held    = held_r;

endmodule

// File: tb/tb_key_event_decoder.sv
// Testbench for key_event_decoder: gesture sequences (directed and random)
// are turned into expected event times by a gesture-level timing model and
// compared cycle by cycle against the DUT outputs.
module tb_key_event_decoder;

  localparam int LONG_CYC = 2000;
  localparam int REP_CYC  = 1000;
  localparam int DCL_CYC  = 1000;
  localparam int LAT      = 2;   // sample edge of a key change -> output edge

  localparam bit [5:0] M_PRESS  = 6'b100000;
  localparam bit [5:0] M_REL    = 6'b010000;
  localparam bit [5:0] M_CLICK  = 6'b001000;
  localparam bit [5:0] M_DCLICK = 6'b000100;
  localparam bit [5:0] M_LONG   = 6'b000010;
  localparam bit [5:0] M_REP    = 6'b000001;
  localparam int I_PRESS = 5, I_REL = 4, I_CLICK = 3, I_DCLICK = 2, I_LONG = 1, I_REP = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_press, key_release, key_click, key_dclick, key_long, key_repeat, key_held;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit drive_en = 1'b0;

  int ps[$];                 // sample edge where key goes low
  int rs[$];                 // sample edge where key goes high again
  int hs[$];                 // expected held intervals [hs, he)
  int he[$];
  int g_gap[$];
  int g_hold[$];
  bit [5:0] exp_ev [int];    // output edge -> expected event mask
  int cnt_ev[6];
  int last_cyc[6];

  key_event_decoder #(
    .N(32), .FREQ(1), .LONG_MS(2), .REPEAT_MS(1), .DCLICK_MS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_press(key_press), .key_release(key_release), .key_click(key_click),
    .key_dclick(key_dclick), .key_long(key_long), .key_repeat(key_repeat),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void add_ev(int t, bit [5:0] m);
    if (exp_ev.exists(t)) exp_ev[t] = exp_ev[t] | m;
    else exp_ev[t] = m;
  endfunction

  function automatic bit level(int s);
    foreach (ps[i]) if (s >= ps[i] && s < rs[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_held(int c);
    foreach (hs[i]) if (c >= hs[i] && c < he[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Gesture-level model: walks press intervals and applies the timing rules.
  task automatic build_model();
    bit armed, second;
    int rel, p, r, pp, rr;
    exp_ev.delete(); hs.delete(); he.delete();
    armed = 1'b0; rel = 0;
    for (int i = 0; i < ps.size(); i++) begin
      p = ps[i]; r = rs[i]; pp = p + LAT; rr = r + LAT; second = 1'b0;
      if (armed) begin
        if (p - rel <= DCL_CYC) second = 1'b1;
        else add_ev(rel + LAT + DCL_CYC, M_CLICK);
        armed = 1'b0;
      end
      add_ev(pp, M_PRESS);
      hs.push_back(pp); he.push_back(rr);
      if (pp + LONG_CYC < rr) begin
        add_ev(pp + LONG_CYC, M_LONG);
        for (int t = pp + LONG_CYC + REP_CYC; t < rr && t < pp + 100000; t += REP_CYC)
          add_ev(t, M_REP);
        add_ev(rr, M_REL);
      end else if (second) begin
        add_ev(rr, M_REL | M_DCLICK);
      end else begin
        add_ev(rr, M_REL);
        armed = 1'b1; rel = r;
      end
    end
    if (armed) add_ev(rel + LAT + DCL_CYC, M_CLICK);
  endtask

  task automatic tick();
    bit [5:0] obs, ex;
    @(posedge clk);
    cyc++;
    #1;
    obs = {key_press, key_release, key_click, key_dclick, key_long, key_repeat};
    ex = exp_ev.exists(cyc) ? exp_ev[cyc] : 6'b000000;
    tests++;
    assert (obs === ex) else begin
      fails++;
      $error("FAIL events cyc=%0d observed=%b expected=%b", cyc, obs, ex);
    end
    tests++;
    assert (key_held === exp_held(cyc)) else begin
      fails++;
      $error("FAIL held cyc=%0d observed=%b expected=%b", cyc, key_held, exp_held(cyc));
    end
    for (int k = 0; k < 6; k++) begin
      if (obs[k] === 1'b1) begin
        cnt_ev[k]++;
        last_cyc[k] = cyc;
      end
    end
    if (drive_en) key_in = level(cyc + 1);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 6; k++) begin
      cnt_ev[k] = 0;
      last_cyc[k] = -1;
    end
  endtask

  task automatic run_model(input int limit);
    int stop;
    build_model();
    stop = cyc;
    foreach (exp_ev[k]) if (k > stop) stop = k;
    stop = stop + 5;
    if (limit > 0 && cyc + limit < stop) stop = cyc + limit;
    clear_counts();
    drive_en = 1'b1;
    key_in = level(cyc + 1);
    while (cyc < stop) tick();
  endtask

  task automatic run_gestures(input int limit);
    int t, p, r;
    ps.delete(); rs.delete();
    t = cyc + 1;
    for (int i = 0; i < g_gap.size(); i++) begin
      p = t + g_gap[i];
      r = p + g_hold[i];
      ps.push_back(p); rs.push_back(r);
      t = r;
    end
    run_model(limit);
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  initial begin
    int k0, ncat;
    rst_n = 1'b0; key_in = 1'b1; drive_en = 1'b0;
    clear_counts();
    repeat (3) tick();
    check_int("reset_outputs", int'({key_press, key_release, key_click, key_dclick,
                                      key_long, key_repeat, key_held}), 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // 1: short click
    g_gap = {10}; g_hold = {100};
    run_gestures(0);
    check_int("t1_clicks", cnt_ev[I_CLICK], 1);
    check_int("t1_dclicks", cnt_ev[I_DCLICK], 0);
    check_int("t1_longs", cnt_ev[I_LONG], 0);
    check_int("t1_rel_minus_press", last_cyc[I_REL] - last_cyc[I_PRESS], 100);
    check_int("t1_click_minus_rel", last_cyc[I_CLICK] - last_cyc[I_REL], DCL_CYC);

    // 2: double click
    g_gap = {10, 300}; g_hold = {100, 100};
    run_gestures(0);
    check_int("t2_presses", cnt_ev[I_PRESS], 2);
    check_int("t2_dclicks", cnt_ev[I_DCLICK], 1);
    check_int("t2_clicks", cnt_ev[I_CLICK], 0);
    check_int("t2_dclick_at_release", last_cyc[I_DCLICK], last_cyc[I_REL]);

    // 3: long press with repeat
    g_gap = {10}; g_hold = {4600};
    run_gestures(0);
    check_int("t3_longs", cnt_ev[I_LONG], 1);
    check_int("t3_repeats", cnt_ev[I_REP], 2);
    check_int("t3_long_minus_press", last_cyc[I_LONG] - last_cyc[I_PRESS], LONG_CYC);
    check_int("t3_rep_minus_long", last_cyc[I_REP] - last_cyc[I_LONG], 2 * REP_CYC);
    check_int("t3_clicks", cnt_ev[I_CLICK] + cnt_ev[I_DCLICK], 0);

    // 4a: second fall seen at cnt = DCL_CYC-1 -> double click
    g_gap = {10, 1000}; g_hold = {100, 100};
    run_gestures(0);
    check_int("t4a_dclicks", cnt_ev[I_DCLICK], 1);
    check_int("t4a_clicks", cnt_ev[I_CLICK], 0);

    // 4b: one cycle later -> click, then a fresh sequence (its own click)
    g_gap = {10, 1001}; g_hold = {100, 100};
    run_gestures(0);
    check_int("t4b_dclicks", cnt_ev[I_DCLICK], 0);
    check_int("t4b_clicks", cnt_ev[I_CLICK], 2);
    check_int("t4b_presses", cnt_ev[I_PRESS], 2);

    // 5: second press held long
    g_gap = {10, 300}; g_hold = {100, 2500};
    run_gestures(0);
    check_int("t5_longs", cnt_ev[I_LONG], 1);
    check_int("t5_clicks", cnt_ev[I_CLICK] + cnt_ev[I_DCLICK], 0);
    check_int("t5_long_minus_press", last_cyc[I_LONG] - last_cyc[I_PRESS], LONG_CYC);

    // 6a: reset asserted mid-hold
    g_gap = {10}; g_hold = {100000};
    run_gestures(1 + 10 + LAT + 1500);
    check_int("t6a_held_before_reset", int'(key_held), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("t6a_async_reset_outputs", int'({key_press, key_release, key_click, key_dclick,
                                               key_long, key_repeat, key_held}), 0);
    ps.delete(); rs.delete();
    build_model();
    drive_en = 1'b0; key_in = 1'b1;
    repeat (4) tick();
    rst_n = 1'b1;
    clear_counts();
    repeat (2600) tick();
    check_int("t6a_no_events_after_reset", cnt_ev[0] + cnt_ev[1] + cnt_ev[2] + cnt_ev[3] +
              cnt_ev[4] + cnt_ev[5], 0);

    // 6b: key held low through reset
    rst_n = 1'b0; key_in = 1'b0; drive_en = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    k0 = cyc;
    ps.delete(); rs.delete();
    ps.push_back(k0 + 1); rs.push_back(k0 + 301);
    run_model(0);
    check_int("t6b_press_after_reset", last_cyc[I_PRESS], k0 + 1 + LAT);
    check_int("t6b_clicks", cnt_ev[I_CLICK], 1);

    // Random gesture sessions
    for (int s = 0; s < 4; s++) begin
      g_gap.delete(); g_hold.delete();
      for (int g = 0; g < 3; g++) begin
        ncat = $urandom_range(0, 2);
        case (ncat)
          0:       g_gap.push_back($urandom_range(1, 50));
          1:       g_gap.push_back($urandom_range(990, 1010));
          default: g_gap.push_back($urandom_range(100, 1200));
        endcase
        ncat = $urandom_range(0, 2);
        case (ncat)
          0:       g_hold.push_back($urandom_range(1, 300));
          1:       g_hold.push_back($urandom_range(1990, 2010));
          default: g_hold.push_back($urandom_range(2990, 3010));
        endcase
      end
      run_gestures(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
